piso_stream: RTL
================

// Module: piso_stream
// PURPOSE
//  Parametrised parallel-in serial-out shifter with valid/ready on both sides.
//  Loads a WIDTH-bit word through a handshake, then emits it one bit per accepted beat, LSB- or MSB-first.
//  Supports output backpressure, first/last framing and back-to-back words with no idle gap.
//  Sits between parallel datapath logic and bit-serial links (UART/SPI-style transmitters).
// PARAMETERS
//  WIDTH      8   bits per word; legal range 2..64
//  CNT_W      $clog2(WIDTH)   bit-counter width; derived, do not override
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-low; synchronous deassertion is the integrator's job
//  in_valid   in   1      parallel word present on in_data
//  in_ready   out  1      block accepts a word this cycle
//  in_data    in   WIDTH  parallel word
//  in_msb     in   1      direction for this word: 1 = MSB first, 0 = LSB first; sampled with in_data
//  s_valid    out  1      serial bit valid
//  s_ready    in   1      downstream accepts the bit
//  s_data     out  1      serial bit
//  s_first    out  1      current bit is bit 0 of the word sequence (first emitted)
//  s_last     out  1      current bit is the final bit of the word
//  busy       out  1      a word is held (same as s_valid)
// BEHAVIOUR
//  - States: IDLE (no word held), SHIFT (word held, bit_cnt = bits already emitted, 0..WIDTH-1).
//  - Reset (rst=0, any time, async): state=IDLE, shift reg=0, bit_cnt=0, dir=0; s_valid=0, s_data=0, s_first=0, s_last=0, busy=0.
//    Reset mid-word discards the word; no partial bits after release.
//  - in_ready = (state==IDLE) | (s_valid & s_ready & s_last). Combinational from s_ready; documented timing path.
//  - Load: in_valid & in_ready at edge N -> shift reg=in_data, dir=in_msb, bit_cnt=0, state=SHIFT.
//    First bit on s_data after edge N (one-cycle latency load->s_valid).
//  - s_data = dir ? sreg[WIDTH-1] : sreg[0]. On beat (s_valid & s_ready): shift toward the emitted end,
//    fill with 0, bit_cnt++.
//  - s_first = s_valid & (bit_cnt==0). s_last = s_valid & (bit_cnt==WIDTH-1).
//  - Last beat with no new load: state -> IDLE, s_valid=0 next cycle, s_data=0.
//  - Last beat with simultaneous load: new word in place at the same edge; s_valid stays 1, s_first=1 next cycle.
//    Zero bubbles between words.
//  - Stall: s_ready=0 holds s_data, s_first, s_last, bit_cnt and the shift reg unchanged. s_valid never drops
//    mid-word (AXI-style: no retraction).
//  - in_valid while SHIFT and not on last beat: in_ready=0; word is not taken and source must hold it.
//  - in_data/in_msb are ignored when no load occurs. Direction cannot change mid-word.
//  - Per word, exactly WIDTH beats; bit_cnt never exceeds WIDTH-1 (wrap to 0 only via reload).
// TESTING
//  1 Reset: rst=0 mid-word (bit_cnt=3), release -> s_valid=0, busy=0, in_ready=1, no further bits emitted.
//  2 LSB single word: WIDTH=8, in_data=8'hA5, in_msb=0, s_ready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive
//    cycles starting 1 cycle after load. s_first on beat 0, s_last on beat 7, then s_valid=0.
//  3 MSB mode: in_data=8'hA5, in_msb=1 -> bits 1,0,1,0,0,1,0,1 (MSB first; check with 8'h01 -> 0x7 then 1).
//  4 Back-to-back: words 8'hFF then 8'h00 offered continuously -> 16 contiguous valid beats;
//    in_ready pulses only on the 8th beat; s_first on beat 8.
//  5 Backpressure: s_ready low on random cycles (~50%) -> s_data/s_last stable while stalled;
//    reassembled word equals input for 200 random words with random in_msb.
//  6 Params: repeat 2 and 4 with WIDTH=2 and WIDTH=33 -> correct bit order and s_last on beat WIDTH-1.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter with valid/ready on both sides, per-word
// LSB/MSB-first order, first/last framing and zero-bubble back-to-back words.
module piso_stream #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_data,
  output logic             s_first,
  output logic             s_last,
  output logic             busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next;
  logic             dir, dir_next;
  logic             beat, at_last, load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      dir     <= 1'b0;
    end else begin
      state   <= state_next;
      sreg    <= sreg_next;
      bit_cnt <= cnt_next;
      dir     <= dir_next;
    end
  end

  // in_ready depends combinationally on s_ready so a new word can replace the
  // old one on its last beat without a bubble.
  always_comb begin
    s_valid    = (state == SHIFT);
    busy       = s_valid;
    at_last    = (bit_cnt == LAST_CNT);
    s_data     = dir ? sreg[WIDTH-1] : sreg[0];
    s_first    = s_valid & (bit_cnt == '0);
    s_last     = s_valid & at_last;
    beat       = s_valid & s_ready;
    in_ready   = (state == IDLE) | (beat & at_last);
    load       = in_valid & in_ready;

    state_next = state;
    sreg_next  = sreg;
    cnt_next   = bit_cnt;
    dir_next   = dir;

    if (load) begin
      state_next = SHIFT;
      sreg_next  = in_data;
      dir_next   = in_msb;
      cnt_next   = '0;
    end else if (beat) begin
      sreg_next = dir ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      if (at_last) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = bit_cnt + 1'b1;
      end
    end
  end

endmodule
